// File: rtl/instr_dispatch.sv
// Instruction dispatcher: captures an instruction, decodes its class field,
// selects one execution unit and waits for its completion or a timeout.
//
// state     | meaning
// ----------|---------------------------------------------------------
// ST_IDLE   | ready for a new instruction
// ST_DECODE | classify captured instruction, latch unit/op
// ST_WAIT   | unit selected, waiting for its done or timer expiry
// ST_RETIRE | one-cycle retire pulse
module instr_dispatch #(
  parameter int IR_W    = 32,
  parameter int OPC_LSB = 16,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ir_valid,
  input  logic [IR_W-1:0] ir,
  output logic            ir_ready,
  input  logic            done_eu,
  input  logic            done_biu,
  input  logic            done_fcu,
  output logic            cs_eu,
  output logic            cs_biu,
  output logic            cs_fcu,
  output logic [1:0]      sel_eu,
  output logic [1:0]      sel_biu,
  output logic            sel_fcu,
  output logic            retire,
  output logic            illegal,
  output logic            timeout,
  output logic            busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_WAIT, ST_RETIRE} state_t;
  typedef enum logic [1:0] {U_EU, U_BIU, U_FCU, U_NONE} unit_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state, state_d;
  logic [IR_W-1:0] ir_q, ir_d;
  unit_t           unit_q, unit_d, dec_unit;
  logic [1:0]      op_q, op_d, dec_op;
  logic [TO_W-1:0] timer_q, timer_d;
  logic            illegal_q, illegal_d, timeout_q, timeout_d;
  logic [5:0]      f;
  logic            unit_done;
  logic            in_wait;
  logic            unused_ir;

  assign f         = ir_q[OPC_LSB+5:OPC_LSB];
  assign unused_ir = ^ir_q;

  // Class decode: the leading-ones count of f picks the class.
  always_comb begin
    dec_unit = U_NONE;
    dec_op   = 2'b00;
    if (!f[5]) begin
      dec_unit = U_EU;
      dec_op   = 2'b00;
    end else if (!f[4]) begin
      dec_unit = U_BIU;
      dec_op   = 2'b00;
    end else if (!f[3]) begin
      dec_unit = U_BIU;
      dec_op   = 2'b01;
    end else if (!f[2]) begin
      dec_unit = U_FCU;
      dec_op   = 2'b00;
    end else if (!f[1]) begin
      dec_unit = U_EU;
      dec_op   = 2'b01;
    end else if (!f[0]) begin
      dec_unit = U_EU;
      dec_op   = 2'b10;
    end
  end

  always_comb begin
    unit_done = 1'b0;
    case (unit_q)
      U_EU:    unit_done = done_eu;
      U_BIU:   unit_done = done_biu;
      U_FCU:   unit_done = done_fcu;
      default: unit_done = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state;
    ir_d      = ir_q;
    unit_d    = unit_q;
    op_d      = op_q;
    timer_d   = timer_q;
    illegal_d = 1'b0;
    timeout_d = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ir_valid) begin
          ir_d    = ir;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_unit == U_NONE) begin
          illegal_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          unit_d  = dec_unit;
          op_d    = dec_op;
          timer_d = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Completion takes priority over an expiring timer.
        if (unit_done) begin
          state_d = ST_RETIRE;
        end else if (timer_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RETIRE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ir_q      <= '0;
      unit_q    <= U_NONE;
      op_q      <= 2'b00;
      timer_q   <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_d;
      ir_q      <= ir_d;
      unit_q    <= unit_d;
      op_q      <= op_d;
      timer_q   <= timer_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // ir_ready/busy are qualified by rst_n so every output is low during reset.
  always_comb begin
    in_wait  = (state == ST_WAIT);
    cs_eu    = in_wait && (unit_q == U_EU);
    cs_biu   = in_wait && (unit_q == U_BIU);
    cs_fcu   = in_wait && (unit_q == U_FCU);
    sel_eu   = cs_eu  ? op_q : 2'b00;
    sel_biu  = cs_biu ? op_q : 2'b00;
    sel_fcu  = cs_fcu & op_q[0];
    retire   = (state == ST_RETIRE);
    illegal  = illegal_q;
    timeout  = timeout_q;
    ir_ready = rst_n && (state == ST_IDLE);
    busy     = rst_n && (state != ST_IDLE);
  end

endmodule

// File: tb/tb_instr_dispatch.sv
// Scoreboard bench for instr_dispatch: a 32-bit build (TIMEOUT=8) and a
// 16-bit build with the class field at bit 0 (TIMEOUT=4).
module tb_instr_dispatch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ir_valid = 1'b0;
  logic        tgt = 1'b0;
  logic [31:0] ir = '0;
  logic        done_eu = 1'b0, done_biu = 1'b0, done_fcu = 1'b0;

  logic       valid_a, ready_a, cs_eu_a, cs_biu_a, cs_fcu_a, sel_fcu_a;
  logic       retire_a, illegal_a, timeout_a, busy_a;
  logic [1:0] sel_eu_a, sel_biu_a;
  logic       valid_b, ready_b, cs_eu_b, cs_biu_b, cs_fcu_b, sel_fcu_b;
  logic       retire_b, illegal_b, timeout_b, busy_b;
  logic [1:0] sel_eu_b, sel_biu_b;

  logic       ready_v, busy_v;
  logic [2:0] cs_v, pulse_a, pulse_b, pulse_v;
  logic [4:0] sel_v;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] sb[$];

  always #5 clk = ~clk;

  assign valid_a = ir_valid & ~tgt;
  assign valid_b = ir_valid & tgt;

  instr_dispatch #(.TIMEOUT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .ir_valid(valid_a), .ir(ir), .ir_ready(ready_a),
    .done_eu(done_eu), .done_biu(done_biu), .done_fcu(done_fcu),
    .cs_eu(cs_eu_a), .cs_biu(cs_biu_a), .cs_fcu(cs_fcu_a),
    .sel_eu(sel_eu_a), .sel_biu(sel_biu_a), .sel_fcu(sel_fcu_a),
    .retire(retire_a), .illegal(illegal_a), .timeout(timeout_a), .busy(busy_a)
  );

  instr_dispatch #(.IR_W(16), .OPC_LSB(0), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .ir_valid(valid_b), .ir(ir[15:0]), .ir_ready(ready_b),
    .done_eu(done_eu), .done_biu(done_biu), .done_fcu(done_fcu),
    .cs_eu(cs_eu_b), .cs_biu(cs_biu_b), .cs_fcu(cs_fcu_b),
    .sel_eu(sel_eu_b), .sel_biu(sel_biu_b), .sel_fcu(sel_fcu_b),
    .retire(retire_b), .illegal(illegal_b), .timeout(timeout_b), .busy(busy_b)
  );

  // Pulses packed as {retire, illegal, timeout}; cs as {fcu, biu, eu}.
  assign pulse_a = {retire_a, illegal_a, timeout_a};
  assign pulse_b = {retire_b, illegal_b, timeout_b};
  assign pulse_v = tgt ? pulse_b : pulse_a;
  assign ready_v = tgt ? ready_b : ready_a;
  assign busy_v  = tgt ? busy_b : busy_a;
  assign cs_v    = tgt ? {cs_fcu_b, cs_biu_b, cs_eu_b} : {cs_fcu_a, cs_biu_a, cs_eu_a};
  assign sel_v   = tgt ? {sel_fcu_b, sel_biu_b, sel_eu_b} : {sel_fcu_a, sel_biu_a, sel_eu_a};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {cs[2:0], sel[4:0]}; cs==0 means illegal class.
  function automatic logic [7:0] model(input logic [5:0] f);
    casez (f)
      6'b0?????: return {3'b001, 5'b0_00_00};
      6'b10????: return {3'b010, 5'b0_00_00};
      6'b110???: return {3'b010, 5'b0_01_00};
      6'b1110??: return {3'b100, 5'b0_00_00};
      6'b11110?: return {3'b001, 5'b0_00_01};
      6'b111110: return {3'b001, 5'b0_00_10};
      default:   return 8'h00;
    endcase
  endfunction

  always @(negedge clk) begin
    if ((tgt ? pulse_a : pulse_b) != 3'b000)
      chk("stray_pulse", {29'd0, tgt ? pulse_a : pulse_b}, 32'd0);
    if (pulse_v != 3'b000) begin
      if (sb.size() == 0) chk("unexpected_pulse", {29'd0, pulse_v}, 32'd0);
      else chk("outcome", {29'd0, pulse_v}, {29'd0, sb.pop_front()});
    end
  end

  // done_k: WAIT cycle (1-based) on which the selected unit's done is high; 0 = never.
  task automatic run(input logic [5:0] f, input int done_k);
    logic [7:0]  m;
    logic [2:0]  ecs, kind, noise;
    logic [31:0] rnd, word;
    int lim, to;
    m    = model(f);
    ecs  = m[7:5];
    to   = tgt ? 4 : 8;
    rnd  = $urandom;
    word = tgt ? {16'h0, rnd[15:6], f} : {rnd[31:22], f, rnd[15:0]};
    kind = (ecs == 3'b000) ? 3'b010 : ((done_k > 0) ? 3'b100 : 3'b001);
    sb.push_back(kind);
    @(negedge clk);
    chk("accept_ready", {31'd0, ready_v}, 32'd1);
    ir = word;
    ir_valid = 1'b1;
    @(posedge clk);
    #1 ir_valid = 1'b0;
    ir = $urandom;
    @(negedge clk);
    chk("decode_ready", {31'd0, ready_v}, 32'd0);
    chk("decode_busy", {31'd0, busy_v}, 32'd1);
    chk("decode_cs", {29'd0, cs_v}, 32'd0);
    if (ecs == 3'b000) begin
      @(negedge clk);
      chk("illegal_pulse", {29'd0, pulse_v}, {29'd0, kind});
      chk("illegal_ready", {31'd0, ready_v}, 32'd1);
      chk("illegal_cs", {29'd0, cs_v}, 32'd0);
      return;
    end
    lim = (done_k > 0) ? done_k : to;
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      chk("wait_cs", {29'd0, cs_v}, {29'd0, ecs});
      chk("wait_sel", {27'd0, sel_v}, {27'd0, m[4:0]});
      chk("wait_ready", {31'd0, ready_v}, 32'd0);
      noise = (c == 1) ? 3'b111 : 3'(($urandom));
      {done_fcu, done_biu, done_eu} = (noise & ~ecs) | ((c == done_k) ? ecs : 3'b000);
    end
    @(negedge clk);
    {done_fcu, done_biu, done_eu} = 3'b000;
    chk("end_cs", {29'd0, cs_v}, 32'd0);
    chk("end_pulse", {29'd0, pulse_v}, {29'd0, kind});
    if (done_k > 0) begin
      chk("retire_ready", {31'd0, ready_v}, 32'd0);
      @(negedge clk);
      chk("retire_once", {29'd0, pulse_v}, 32'd0);
    end
    chk("back_ready", {31'd0, ready_v}, 32'd1);
  endtask

  task automatic set_tgt(input logic v);
    @(posedge clk);
    #1 tgt = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0] cls [6];
    logic [5:0] fr;
    cls = '{6'b000101, 6'b101010, 6'b110111, 6'b111000, 6'b111101, 6'b111110};

    repeat (3) @(negedge clk);
    chk("rst_ready_a", {31'd0, ready_a}, 32'd0);
    chk("rst_ready_b", {31'd0, ready_b}, 32'd0);
    chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
    chk("rst_outs_a", {29'd0, cs_eu_a, cs_biu_a, cs_fcu_a}, 32'd0);
    chk("rst_pulses", {26'd0, pulse_a, pulse_b}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready_a", {31'd0, ready_a}, 32'd1);
    chk("post_rst_ready_b", {31'd0, ready_b}, 32'd1);

    fr = {1'b0, 5'($urandom)};
    run(fr, 2);
    run(6'b110000, 6);
    run(6'b111111, 0);
    foreach (cls[i]) run(cls[i], $urandom_range(1, 3));
    run(6'b111000, 0);

    set_tgt(1'b1);
    run(6'b111110, 0);
    run(6'b111110, 4);
    run(6'b100000, 1);
    set_tgt(1'b0);

    // Reset while a branch sits in WAIT.
    @(negedge clk);
    ir = 32'h0038_0000;
    ir_valid = 1'b1;
    @(posedge clk);
    #1 ir_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rw_cs_before", {29'd0, cs_v}, 32'd4);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rw_cs_after", {29'd0, cs_v}, 32'd0);
    chk("rw_ready_low", {31'd0, ready_v}, 32'd0);
    chk("rw_busy_low", {31'd0, busy_v}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rw_ready_release", {31'd0, ready_v}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("rw_no_pulse", {29'd0, pulse_v}, 32'd0);
    end

    for (int i = 0; i < 24; i++) run(6'($urandom), $urandom_range(0, 8));

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
